// File: rtl/libv_deque.sv
// libv_deque: storage-side responder for the libv deque command protocol.
//
// Holds up to N entries of W bits in a circular buffer. Commands can push or
// pop at either end. Popped data comes back on a registered response channel.
// N may be any integer >= 2; pointer wrap is explicit, so N does not have to
// be a power of two.
//
// Ports:
//   clk      in   rising-edge clock
//   arst_n   in   asynchronous active-low reset
//   cmd_vld  in   command valid
//   cmd_op   in   libv_pkg::deque_op_t command
//   cmd_dat  in   push data (ignored for pops)
//   cmd_rdy  out  command ready (combinational)
//   rsp_vld  out  pop response valid (registered)
//   rsp_dat  out  popped data (registered)
//   rsp_rdy  in   response accepted by consumer
//   err      out  one-cycle pulse: last accepted command was rejected
//   empty    out  occupancy == 0 (registered)
//   full     out  occupancy == N (registered)

package libv_pkg;
  typedef enum logic [1:0] {
    OpPushFront = 2'b00,
    OpPopFront  = 2'b01,
    OpPushBack  = 2'b10,
    OpPopBack   = 2'b11
  } deque_op_t;
endpackage

module libv_deque
  import libv_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         cmd_vld,
  input  deque_op_t    cmd_op,
  input  logic [W-1:0] cmd_dat,
  output logic         cmd_rdy,
  output logic         rsp_vld,
  output logic [W-1:0] rsp_dat,
  input  logic         rsp_rdy,
  output logic         err,
  output logic         empty,
  output logic         full
);

  localparam int            PW       = (N > 1) ? $clog2(N) : 1;
  localparam int            CW       = $clog2(N + 1);
  localparam logic [PW-1:0] LAST     = PW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic [W-1:0]  r_mem [N];
  logic [PW-1:0] r_head;     // index of the front element
  logic [PW-1:0] r_tail;     // index of the next free back slot
  logic [CW-1:0] r_count;
  logic          r_rsp_vld;
  logic [W-1:0]  r_rsp_dat;
  logic          r_err;
  logic          r_empty;
  logic          r_full;

  logic [PW-1:0] w_head_inc;
  logic [PW-1:0] w_head_dec;
  logic [PW-1:0] w_tail_inc;
  logic [PW-1:0] w_tail_dec;
  logic          w_accept;
  logic          w_is_push;
  logic          w_is_pop;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_reject;
  logic [CW-1:0] w_count_nxt;
  logic [W-1:0]  w_pop_dat;

  // Explicit modulo-N wrap in both directions.
  assign w_head_inc = (r_head == LAST) ? '0 : r_head + 1'b1;
  assign w_head_dec = (r_head == '0) ? LAST : r_head - 1'b1;
  assign w_tail_inc = (r_tail == LAST) ? '0 : r_tail + 1'b1;
  assign w_tail_dec = (r_tail == '0) ? LAST : r_tail - 1'b1;

  // Handshake: a command is taken on cmd_vld && cmd_rdy. cmd_rdy only drops
  // while a response is held (rsp_vld && !rsp_rdy), so a pop can always land
  // in the response register in the cycle it is accepted. A response is
  // consumed on rsp_vld && rsp_rdy; a pop accepted in that same cycle
  // overwrites it and keeps rsp_vld high.
  assign cmd_rdy  = !(r_rsp_vld && !rsp_rdy);
  assign w_accept = cmd_vld && cmd_rdy;

  assign w_is_push = (cmd_op == OpPushFront) || (cmd_op == OpPushBack);
  assign w_is_pop  = (cmd_op == OpPopFront) || (cmd_op == OpPopBack);
  assign w_push_ok = w_accept && w_is_push && !r_full;
  assign w_pop_ok  = w_accept && w_is_pop && !r_empty;
  assign w_reject  = w_accept && ((w_is_push && r_full) || (w_is_pop && r_empty));

  assign w_pop_dat = (cmd_op == OpPopFront) ? r_mem[r_head] : r_mem[w_tail_dec];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      if (cmd_op == OpPushBack) begin
        r_mem[r_tail] <= cmd_dat;
      end else begin
        r_mem[w_head_dec] <= cmd_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_err     <= 1'b0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
    end else begin
      r_err   <= w_reject;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_FULL);

      if (w_push_ok) begin
        if (cmd_op == OpPushBack) begin
          r_tail <= w_tail_inc;
        end else begin
          r_head <= w_head_dec;
        end
      end

      if (w_pop_ok) begin
        if (cmd_op == OpPopFront) begin
          r_head <= w_head_inc;
        end else begin
          r_tail <= w_tail_dec;
        end
      end

      if (w_pop_ok) begin
        r_rsp_vld <= 1'b1;
        r_rsp_dat <= w_pop_dat;
      end else if (r_rsp_vld && rsp_rdy) begin
        r_rsp_vld <= 1'b0;
      end
    end
  end

  assign rsp_vld = r_rsp_vld;
  assign rsp_dat = r_rsp_dat;
  assign err     = r_err;
  assign empty   = r_empty;
  assign full    = r_full;

  // Every 2-bit opcode is legal; only an unknown opcode is flagged.
  a_cmd_op_known: assert property (@(posedge clk) disable iff (!arst_n)
    cmd_vld |-> !$isunknown(cmd_op));

endmodule

// File: doc/libv_deque.md
Name: libv_deque

Overview:
- Storage-side responder for the libv deque command protocol (deque_op_t: OpPushFront=2'b00, OpPopFront=2'b01, OpPushBack=2'b10, OpPopBack=2'b11).
- Accepts one command per cycle on a valid/ready channel and holds up to N entries in a circular buffer.
- Returns popped data on a registered valid/ready response channel.
- Sits between any libv command issuer and its consumer as a reusable double-ended queue.

Parameters:
- N, 8, entry count; any integer >= 2, not restricted to powers of two.
- W, 32, data width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- cmd_vld  in  1  command valid.
- cmd_op  in  2  libv_pkg::deque_op_t command.
- cmd_dat  in  W  push data; ignored for pops.
- cmd_rdy  out  1  command ready.
- rsp_vld  out  1  pop response valid.
- rsp_dat  out  W  popped data.
- rsp_rdy  in  1  response accepted by consumer.
- err  out  1  one-cycle pulse: last accepted command was rejected.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == N.

Behaviour:
- Reset (arst_n low, asynchronous): head=0, tail=0, count=0, rsp_vld=0, rsp_dat=0, err=0, empty=1, full=0. Storage contents are not reset.
- Pointers: head indexes the front element; tail indexes the next free back slot. Pointer width is $clog2(N); count width is $clog2(N+1).
- Increment and decrement wrap explicitly at N: N-1 + 1 = 0, 0 - 1 = N-1. Power-of-two N must not be assumed.
- Handshake:
  - cmd_rdy = !(rsp_vld && !rsp_rdy), combinational. A new command is blocked only while an undelivered response is stalled.
  - A command is accepted when cmd_vld && cmd_rdy.
  - rsp_vld clears on rsp_vld && rsp_rdy unless a new pop completes in the same cycle.
- Accepted commands, effect visible the next cycle:
  - OpPushBack: mem[tail]=cmd_dat; tail++; count++.
  - OpPushFront: head--; mem[head-1]=cmd_dat; count++.
  - OpPopFront: rsp_dat<=mem[head]; rsp_vld<=1; head++; count--.
  - OpPopBack: rsp_dat<=mem[tail-1]; rsp_vld<=1; tail--; count--.
- Pop latency is 1 cycle from acceptance to rsp_vld.
- Back-to-back pops with rsp_rdy held high give one response per cycle.
- rsp_dat is stable while rsp_vld && !rsp_rdy.
- Push when full: data dropped, no state change, err=1 for exactly one cycle.
- Pop when empty: no response, no state change, err=1 for one cycle.
- Simultaneous rsp handshake and new pop acceptance: rsp_vld stays 1 and rsp_dat takes the new value.
- empty and full are registered and always consistent with count after each edge.
- An idle cycle (no accepted command) leaves all state unchanged and drives err=0.
- Reset asserted mid-stream: pending response and all contents are discarded immediately. The first command after release sees an empty deque.
- Illegal or X cmd_op with cmd_vld=1: simulation assertion fires; no synthesised error path.

Test Plan:
- PushBack 0x1, 0x2, 0x3, then PopFront x3 with rsp_rdy=1 -> rsp_dat 0x1, 0x2, 0x3 on consecutive cycles, each 1 cycle after acceptance; empty=1 after the last pop.
- PushFront 0xA, PushBack 0xB, PushFront 0xC, then PopBack x3 -> 0xB, 0xA, 0xC; empty=1 at the end.
- N=8: 8 PushBacks -> full=1; 9th PushBack 0xFF -> err pulse of 1 cycle, count stays 8. Draining with PopFront never returns 0xFF.
- From reset, PopFront -> err=1 for one cycle, rsp_vld=0, head/tail stay 0. PopBack behaves the same.
- N=5 wrap: alternate PushBack/PopFront 12 times with values 0..11 -> responses 0..11 in order. Then 5 PushFronts 0x20..0x24 -> PopFront returns 0x24.
- PopFront with rsp_rdy=0 for 3 cycles -> rsp_vld=1, rsp_dat stable, cmd_rdy=0. Assert arst_n low mid-stall -> rsp_vld=0, empty=1, cmd_rdy=1 immediately.
